axi_sram_slave: RTL and testbench



---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_sram_array.sv | 29 ++
 rtl/axi_sram_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the responder FSM state type.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam int unsigned MAX_BURST_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_R_WAIT = 3'd1,
        ST_R_DATA = 3'd2,
        ST_W_DATA = 3'd3,
        ST_W_RESP = 3'd4
    } sram_state_e;

    // The response encodings are ordered by severity, so the larger code wins.
    function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_sram_array.sv
// Byte-writable word array: combinational read port, write committed on the clock edge.
module axi_sram_array #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH  = 1024,
    localparam int unsigned LP_IDX_W  = $clog2(MEM_DEPTH),
    localparam int unsigned LP_STRB_W = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  i_we,
    input  logic [LP_IDX_W-1:0]   i_idx,
    input  logic [LP_STRB_W-1:0]  i_wstrb,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Per-byte-lane write; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(LP_STRB_W); b++) begin
            if (i_we && i_wstrb[b]) begin
                r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 memory responder: one transaction at a time, programmable read latency,
// byte-strobed writes into axi_sram_array, OKAY/SLVERR/DECERR reporting.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned           RD_LATENCY = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    input  logic [ID_WIDTH-1:0]       arid_i,
    input  logic [ADDR_WIDTH-1:0]     araddr_i,
    input  logic [7:0]                arlen_i,
    input  logic [2:0]                arsize_i,
    input  logic [1:0]                arburst_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [ID_WIDTH-1:0]       rid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [ID_WIDTH-1:0]       awid_i,
    input  logic [ADDR_WIDTH-1:0]     awaddr_i,
    input  logic [7:0]                awlen_i,
    input  logic [2:0]                awsize_i,
    input  logic [1:0]                awburst_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                      wlast_i,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic [ID_WIDTH-1:0]       bid_o,
    output logic [1:0]                bresp_o
);

    localparam int unsigned LP_STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned LP_BYTE_BITS = $clog2(LP_STRB_W);
    localparam int unsigned LP_IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned LP_LEN_W     = $clog2(MAX_BURST_LEN);
    localparam int unsigned LP_LAT_W     = (RD_LATENCY == 0) ? 1 : $clog2(RD_LATENCY + 1);
    // One extra bit so the upper bound cannot overflow at the top of the address map
    localparam logic [ADDR_WIDTH:0] LP_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LP_HI = LP_LO + (ADDR_WIDTH+1)'(MEM_DEPTH * LP_STRB_W);

    sram_state_e           r_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   r_id, w_id_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [LP_LEN_W-1:0]   r_len, w_len_nxt;
    logic [2:0]            r_size, w_size_nxt;
    logic [1:0]            r_burst, w_burst_nxt;
    logic [LP_LEN_W-1:0]   r_beat_cnt, w_beat_nxt;
    logic [LP_LAT_W-1:0]   r_lat_cnt, w_lat_nxt;
    logic [1:0]            r_bresp, w_bresp_nxt;

    logic                  w_in_range;
    logic                  w_hdr_err;
    logic                  w_beat_last;
    logic [1:0]            w_beat_resp;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [LP_IDX_W-1:0]   w_idx;
    logic [ADDR_WIDTH-1:0] w_addr_adv;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    axi_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .i_we    (w_mem_we),
        .i_idx   (w_idx),
        .i_wstrb (wstrb_i),
        .i_wdata (wdata_i),
        .o_rdata (w_mem_rdata)
    );

    // Decode, error classification and address advance for the current beat
    always_comb begin
        w_in_range  = ({1'b0, r_addr} >= LP_LO) && ({1'b0, r_addr} < LP_HI);
        w_offset    = r_addr - BASE_ADDR;
        w_idx       = LP_IDX_W'(w_offset >> LP_BYTE_BITS);
        w_hdr_err   = (r_size > 3'(LP_BYTE_BITS)) || (r_burst == BURST_WRAP) ||
                      (r_burst == BURST_RSVD);
        w_beat_last = (r_beat_cnt == r_len);
        if (!w_in_range) begin
            w_beat_resp = RESP_DECERR;
        end else if (w_hdr_err) begin
            w_beat_resp = RESP_SLVERR;
        end else begin
            w_beat_resp = RESP_OKAY;
        end
        case (r_burst)
            BURST_FIXED: w_addr_adv = r_addr;
            default:     w_addr_adv = r_addr + (ADDR_WIDTH'(1) << r_size);
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched transaction header and burst counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id       <= {ID_WIDTH{1'b0}};
            r_addr     <= {ADDR_WIDTH{1'b0}};
            r_len      <= {LP_LEN_W{1'b0}};
            r_size     <= 3'd0;
            r_burst    <= 2'b00;
            r_beat_cnt <= {LP_LEN_W{1'b0}};
            r_lat_cnt  <= {LP_LAT_W{1'b0}};
            r_bresp    <= RESP_OKAY;
        end else begin
            r_id       <= w_id_nxt;
            r_addr     <= w_addr_nxt;
            r_len      <= w_len_nxt;
            r_size     <= w_size_nxt;
            r_burst    <= w_burst_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_lat_cnt  <= w_lat_nxt;
            r_bresp    <= w_bresp_nxt;
        end
    end

    // Next-state and channel outputs; every output is zero outside its own state
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_size_nxt  = r_size;
        w_burst_nxt = r_burst;
        w_beat_nxt  = r_beat_cnt;
        w_lat_nxt   = r_lat_cnt;
        w_bresp_nxt = r_bresp;
        w_mem_we    = 1'b0;
        arready_o   = 1'b0;
        awready_o   = 1'b0;
        wready_o    = 1'b0;
        rvalid_o    = 1'b0;
        rid_o       = {ID_WIDTH{1'b0}};
        rdata_o     = {DATA_WIDTH{1'b0}};
        rresp_o     = RESP_OKAY;
        rlast_o     = 1'b0;
        bvalid_o    = 1'b0;
        bid_o       = {ID_WIDTH{1'b0}};
        bresp_o     = RESP_OKAY;
        case (r_state)
            ST_IDLE: begin
                // Readies are masked while reset is held; writes win a tie
                awready_o = ~rst_i;
                arready_o = ~rst_i & ~awvalid_i;
                if (awvalid_i) begin
                    w_id_nxt    = awid_i;
                    w_addr_nxt  = awaddr_i;
                    w_len_nxt   = awlen_i;
                    w_size_nxt  = awsize_i;
                    w_burst_nxt = awburst_i;
                    w_beat_nxt  = {LP_LEN_W{1'b0}};
                    w_bresp_nxt = RESP_OKAY;
                    w_state_nxt = ST_W_DATA;
                end else if (arvalid_i) begin
                    w_id_nxt    = arid_i;
                    w_addr_nxt  = araddr_i;
                    w_len_nxt   = arlen_i;
                    w_size_nxt  = arsize_i;
                    w_burst_nxt = arburst_i;
                    w_beat_nxt  = {LP_LEN_W{1'b0}};
                    w_lat_nxt   = LP_LAT_W'(RD_LATENCY);
                    w_state_nxt = ST_R_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_R_WAIT: begin
                if (r_lat_cnt == {LP_LAT_W{1'b0}}) begin
                    w_state_nxt = ST_R_DATA;
                end else begin
                    w_lat_nxt = r_lat_cnt - LP_LAT_W'(1);
                end
            end
            ST_R_DATA: begin
                rvalid_o = 1'b1;
                rid_o    = r_id;
                rdata_o  = w_in_range ? w_mem_rdata : {DATA_WIDTH{1'b0}};
                rresp_o  = w_beat_resp;
                rlast_o  = w_beat_last;
                if (rready_i) begin
                    w_beat_nxt  = r_beat_cnt + LP_LEN_W'(1);
                    w_addr_nxt  = w_addr_adv;
                    w_state_nxt = w_beat_last ? ST_IDLE : ST_R_DATA;
                end else begin
                    w_state_nxt = ST_R_DATA;
                end
            end
            ST_W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    w_mem_we    = w_in_range;
                    w_beat_nxt  = r_beat_cnt + LP_LEN_W'(1);
                    w_addr_nxt  = w_addr_adv;
                    // A wlast that disagrees with the burst length, either way, is a slave error
                    w_bresp_nxt = resp_merge(r_bresp, resp_merge(w_beat_resp,
                                  (wlast_i != w_beat_last) ? RESP_SLVERR : RESP_OKAY));
                    w_state_nxt = (wlast_i || w_beat_last) ? ST_W_RESP : ST_W_DATA;
                end else begin
                    w_state_nxt = ST_W_DATA;
                end
            end
            ST_W_RESP: begin
                bvalid_o = 1'b1;
                bid_o    = r_id;
                bresp_o  = r_bresp;
                if (bready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_W_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scenario-driven bench for axi_sram_slave with R and B expectation queues.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int RD_LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        arvalid_i = 1'b0, arready_o;
    logic [3:0]  arid_i = 4'd0;
    logic [31:0] araddr_i = 32'd0;
    logic [7:0]  arlen_i = 8'd0;
    logic [2:0]  arsize_i = 3'd0;
    logic [1:0]  arburst_i = 2'd0;
    logic        rvalid_o, rready_i = 1'b0;
    logic [3:0]  rid_o;
    logic [63:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        awvalid_i = 1'b0, awready_o;
    logic [3:0]  awid_i = 4'd0;
    logic [31:0] awaddr_i = 32'd0;
    logic [7:0]  awlen_i = 8'd0;
    logic [2:0]  awsize_i = 3'd0;
    logic [1:0]  awburst_i = 2'd0;
    logic        wvalid_i = 1'b0, wready_o;
    logic [63:0] wdata_i = 64'd0;
    logic [7:0]  wstrb_i = 8'd0;
    logic        wlast_i = 1'b0;
    logic        bvalid_o, bready_i = 1'b0;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;

    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    r_exp_t r_q[$];
    b_exp_t b_q[$];
    logic [63:0] wbuf [8];
    logic [7:0]  sbuf [8];
    int n_tests = 0;
    int n_fail  = 0;

    axi_sram_slave #(.RD_LATENCY(RD_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i),
        .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rid_o(rid_o), .rdata_o(rdata_o),
        .rresp_o(rresp_o), .rlast_o(rlast_o),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awid_i(awid_i), .awaddr_i(awaddr_i),
        .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .wlast_i(wlast_i), .bvalid_o(bvalid_o), .bready_i(bready_i), .bid_o(bid_o),
        .bresp_o(bresp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc;
        awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
        awvalid_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk_i); cyc++; end while (!awready_o && cyc < 64);
        if (!awready_o) begin
            n_tests++; n_fail++;
            $display("FAIL aw_timeout: awready got 0 want 1 within 64 cycles");
        end
        @(posedge clk_i); #1;
        awvalid_i = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc;
        arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk_i); cyc++; end while (!arready_o && cyc < 64);
        if (!arready_o) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout: arready got 0 want 1 within 64 cycles");
        end
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
    endtask

    // Sends nbeats W beats from wbuf/sbuf, asserting wlast on beat index last_at (-1: never).
    task automatic w_send(input int nbeats, input int last_at);
        int cyc;
        for (int i = 0; i < nbeats; i++) begin
            wdata_i = wbuf[i]; wstrb_i = sbuf[i]; wlast_i = (i == last_at);
            wvalid_i = 1'b1;
            cyc = 0;
            do begin @(negedge clk_i); cyc++; end while (!wready_o && cyc < 64);
            if (!wready_o) begin
                n_tests++; n_fail++;
                $display("FAIL w_timeout: beat %0d wready got 0 want 1", i);
            end
            @(posedge clk_i); #1;
        end
        wvalid_i = 1'b0; wlast_i = 1'b0;
    endtask

    task automatic b_check();
        int cyc;
        b_exp_t e;
        bready_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk_i); cyc++; end while (!bvalid_o && cyc < 64);
        n_tests++;
        if (!bvalid_o || b_q.size() == 0) begin
            n_fail++;
            $display("FAIL b_timeout: bvalid got %b want 1 (queued %0d)", bvalid_o, b_q.size());
        end else begin
            e = b_q.pop_front();
            if (bid_o !== e.id || bresp_o !== e.resp) begin
                n_fail++;
                $display("FAIL b_resp: got id %h resp %b, want id %h resp %b",
                         bid_o, bresp_o, e.id, e.resp);
            end
        end
        @(posedge clk_i); #1;
        bready_i = 1'b0;
    endtask

    // Collects n R beats against r_q; stall toggles rready every cycle starting low.
    task automatic r_check(input int n, input bit stall, input int exp_lat);
        int cyc;
        int beats;
        r_exp_t e;
        rready_i = stall ? 1'b0 : 1'b1;
        cyc = 0;
        do begin @(negedge clk_i); cyc++; end while (!rvalid_o && cyc < 64);
        if (!rvalid_o) begin
            n_tests++; n_fail++;
            $display("FAIL r_timeout: rvalid got 0 want 1 within 64 cycles");
            rready_i = 1'b0;
            return;
        end
        if (exp_lat >= 0) begin
            n_tests++;
            if (cyc != exp_lat) begin
                n_fail++;
                $display("FAIL r_latency: first rvalid after %0d cycles, want %0d", cyc, exp_lat);
            end
        end
        beats = 0; cyc = 0;
        while (beats < n && cyc < 64) begin
            cyc++;
            n_tests++;
            if (r_q.size() == 0) begin
                n_fail++;
                $display("FAIL r_queue: beat %0d with no expectation queued", beats);
                break;
            end
            e = r_q[0];
            if (rvalid_o !== 1'b1 || rid_o !== e.id || rdata_o !== e.data ||
                rresp_o !== e.resp || rlast_o !== e.last) begin
                n_fail++;
                $display("FAIL r_beat%0d(rready=%b): got v%b id %h data %h resp %b last %b, want v1 id %h data %h resp %b last %b",
                         beats, rready_i, rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
                         e.id, e.data, e.resp, e.last);
            end
            if (rready_i) begin
                void'(r_q.pop_front());
                beats++;
            end
            @(posedge clk_i); #1;
            rready_i = stall ? ~rready_i : 1'b1;
            if (beats < n) @(negedge clk_i);
        end
        rready_i = 1'b0;
        if (beats < n) begin
            n_tests++; n_fail++;
            $display("FAIL r_count: got %0d beats want %0d", beats, n);
        end
    endtask

    task automatic push_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp,
                          input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        b_q.push_back(e);
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b1;
        #1;
        n_tests++;
        if ({arready_o, awready_o, wready_o, rvalid_o, bvalid_o, rlast_o} !== 6'b0 ||
            rdata_o !== 64'd0 || rresp_o !== 2'b00 || rid_o !== 4'd0 ||
            bid_o !== 4'd0 || bresp_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy %b%b%b vld %b%b rdata %h, want all 0",
                     arready_o, awready_o, wready_o, rvalid_o, bvalid_o, rdata_o);
        end
        repeat (3) @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (awready_o !== 1'b1 || arready_o !== 1'b1 || wready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: got aw %b ar %b w %b, want 1 1 0",
                     awready_o, arready_o, wready_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_single();
        wbuf[0] = 64'h1122_3344_5566_7788; sbuf[0] = 8'hFF;
        push_b(4'd3, RESP_OKAY);
        aw_send(4'd3, 32'h8000_0010, 8'd0, 3'd3, BURST_INCR);
        w_send(1, 0);
        b_check();
        push_r(4'd6, 64'h1122_3344_5566_7788, RESP_OKAY, 1'b1);
        ar_send(4'd6, 32'h8000_0010, 8'd0, 3'd3, BURST_INCR);
        r_check(1, 1'b0, RD_LAT + 2);
    endtask

    task automatic test_partial();
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'hFF;
        push_b(4'd1, RESP_OKAY);
        aw_send(4'd1, 32'h8000_0020, 8'd0, 3'd3, BURST_INCR);
        w_send(1, 0);
        b_check();
        wbuf[0] = 64'd0; sbuf[0] = 8'h0F;
        push_b(4'd2, RESP_OKAY);
        aw_send(4'd2, 32'h8000_0020, 8'd0, 3'd3, BURST_INCR);
        w_send(1, 0);
        b_check();
        push_r(4'd7, 64'hFFFF_FFFF_0000_0000, RESP_OKAY, 1'b1);
        ar_send(4'd7, 32'h8000_0020, 8'd0, 3'd3, BURST_INCR);
        r_check(1, 1'b0, -1);
    endtask

    task automatic test_incr_burst();
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF;
        end
        push_b(4'hA, RESP_OKAY);
        aw_send(4'hA, 32'h8000_0100, 8'd3, 3'd3, BURST_INCR);
        w_send(4, 3);
        b_check();
        for (int i = 0; i < 4; i++) push_r(4'hB, 64'(i + 1), RESP_OKAY, i == 3);
        ar_send(4'hB, 32'h8000_0100, 8'd3, 3'd3, BURST_INCR);
        r_check(4, 1'b1, RD_LAT + 2);
    endtask

    task automatic test_decerr();
        wbuf[0] = 64'hA5A5_0000_1234_5678; sbuf[0] = 8'hFF;
        push_b(4'd1, RESP_OKAY);
        aw_send(4'd1, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR);
        w_send(1, 0);
        b_check();
        // 0x8000_2000 aliases word 0 after index truncation, so a leaked write would show
        wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        push_b(4'd2, RESP_DECERR);
        aw_send(4'd2, 32'h8000_2000, 8'd0, 3'd3, BURST_INCR);
        w_send(1, 0);
        b_check();
        push_r(4'd3, 64'd0, RESP_DECERR, 1'b1);
        ar_send(4'd3, 32'h7FFF_FFF8, 8'd0, 3'd3, BURST_INCR);
        r_check(1, 1'b0, -1);
        push_r(4'd4, 64'hA5A5_0000_1234_5678, RESP_OKAY, 1'b1);
        ar_send(4'd4, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR);
        r_check(1, 1'b0, -1);
        wbuf[0] = 64'h0BAD_CAFE_0000_0001;
        push_b(4'd5, RESP_OKAY);
        aw_send(4'd5, 32'h8000_1FF8, 8'd0, 3'd3, BURST_INCR);
        w_send(1, 0);
        b_check();
        push_r(4'd6, 64'h0BAD_CAFE_0000_0001, RESP_OKAY, 1'b1);
        ar_send(4'd6, 32'h8000_1FF8, 8'd0, 3'd3, BURST_INCR);
        r_check(1, 1'b0, -1);
    endtask

    task automatic test_simultaneous();
        int cyc;
        arid_i = 4'd5; araddr_i = 32'h8000_0010; arlen_i = 8'd0; arsize_i = 3'd3;
        arburst_i = BURST_INCR;
        awid_i = 4'd9; awaddr_i = 32'h8000_0018; awlen_i = 8'd0; awsize_i = 3'd3;
        awburst_i = BURST_INCR;
        arvalid_i = 1'b1; awvalid_i = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (arready_o !== 1'b0 || awready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_ready: got ar %b aw %b, want ar 0 aw 1", arready_o, awready_o);
        end
        @(posedge clk_i); #1;
        awvalid_i = 1'b0;
        wbuf[0] = 64'h5555_AAAA_5555_AAAA; sbuf[0] = 8'hFF;
        w_send(1, 0);
        push_b(4'd9, RESP_OKAY);
        b_check();
        cyc = 0;
        do begin @(negedge clk_i); cyc++; end while (!arready_o && cyc < 64);
        if (!arready_o) begin
            n_tests++; n_fail++;
            $display("FAIL tie_ar_timeout: arready got 0 want 1");
        end
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        push_r(4'd5, 64'h1122_3344_5566_7788, RESP_OKAY, 1'b1);
        r_check(1, 1'b0, RD_LAT + 2);
    endtask

    task automatic test_errors();
        // WRAP: SLVERR, advances like INCR, data still committed
        wbuf[0] = 64'hA; wbuf[1] = 64'hB; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
        push_b(4'd1, RESP_SLVERR);
        aw_send(4'd1, 32'h8000_0200, 8'd1, 3'd3, BURST_WRAP);
        w_send(2, 1);
        b_check();
        push_r(4'd2, 64'hA, RESP_OKAY, 1'b0);
        push_r(4'd2, 64'hB, RESP_OKAY, 1'b1);
        ar_send(4'd2, 32'h8000_0200, 8'd1, 3'd3, BURST_INCR);
        r_check(2, 1'b0, -1);
        // Missing wlast on the final beat
        wbuf[0] = 64'hC;
        push_b(4'd3, RESP_SLVERR);
        aw_send(4'd3, 32'h8000_0300, 8'd0, 3'd3, BURST_INCR);
        w_send(1, -1);
        b_check();
        push_r(4'd4, 64'hC, RESP_OKAY, 1'b0);
        push_r(4'd4, 64'hC, RESP_OKAY, 1'b1);
        ar_send(4'd4, 32'h8000_0300, 8'd1, 3'd3, BURST_FIXED);
        r_check(2, 1'b0, -1);
        // Early wlast terminates the burst after two beats
        wbuf[0] = 64'hD0; wbuf[1] = 64'hD1;
        push_b(4'd5, RESP_SLVERR);
        aw_send(4'd5, 32'h8000_0400, 8'd3, 3'd3, BURST_INCR);
        w_send(2, 1);
        b_check();
        push_r(4'd6, 64'hC, RESP_SLVERR, 1'b1);
        ar_send(4'd6, 32'h8000_0300, 8'd0, 3'd4, BURST_INCR);
        r_check(1, 1'b0, -1);
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        ar_send(4'd2, 32'h8000_0100, 8'd3, 3'd3, BURST_INCR);
        rready_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk_i); cyc++; end while (!rvalid_o && cyc < 64);
        n_tests++;
        if (rvalid_o !== 1'b1 || rdata_o !== 64'd1) begin
            n_fail++;
            $display("FAIL mid_first_beat: got v%b data %h, want v1 data 1", rvalid_o, rdata_o);
        end
        @(posedge clk_i); #1;
        rready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        n_tests++;
        if ({rvalid_o, bvalid_o, arready_o, awready_o, wready_o, rlast_o} !== 6'b0 ||
            rdata_o !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got rvalid %b rdata %h, want all 0", rvalid_o, rdata_o);
        end
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        push_r(4'd8, 64'h1122_3344_5566_7788, RESP_OKAY, 1'b1);
        ar_send(4'd8, 32'h8000_0010, 8'd0, 3'd3, BURST_INCR);
        r_check(1, 1'b0, RD_LAT + 2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_incr_burst();
        test_decerr();
        test_simultaneous();
        test_errors();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
